// File: rtl/uart_proto_pkg.sv
// Shared constants for the delay-shift UART link (both directions).
// Framing characters and formatter state encoding.
package uart_proto_pkg;

  localparam logic [7:0] BASE        = 8'h30;
  localparam logic [7:0] STOP_SIGNAL = 8'h73;
  localparam logic [7:0] CR          = 8'h0D;
  localparam logic [7:0] LF          = 8'h0A;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CONVERT   = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_START     = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;
  localparam logic [2:0] ST_FINISH    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_CONVERT   = ST_CONVERT,
    S_LOAD      = ST_LOAD,
    S_START     = ST_START,
    S_WAIT_ACK  = ST_WAIT_ACK,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_FINISH    = ST_FINISH
  } fmt_state_t;

  function automatic logic [7:0] ascii_digit(
    input logic [3:0] d
  );
    return BASE + {4'b0, d};
  endfunction

endpackage

// File: rtl/bin8_to_bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter.
// Shift-and-add-3, one bit per cycle, 8 cycles start to done.
module bin8_to_bcd (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_bin,
  output logic        o_done,
  output logic [11:0] o_bcd
);

  logic [7:0]  sh_q;
  logic [11:0] bcd_q;
  logic [2:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [11:0] adj;
  logic [19:0] nxt;

  function automatic logic [3:0] add3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Correct each nibble, then shift the next binary bit in.
  always_comb begin
    adj = {add3(bcd_q[11:8]),
           add3(bcd_q[7:4]),
           add3(bcd_q[3:0])};
    nxt = {adj, sh_q} << 1;
  end

  // Conversion sequencer; done pulses after the 8th shift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (i_start) begin
      sh_q   <= i_bin;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      bcd_q <= nxt[19:8];
      sh_q  <= nxt[7:0];
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign o_done = done_q;
  assign o_bcd  = bcd_q;

endmodule

// File: rtl/uart_report_formatter.sv
// Serialises a shift-status report as ASCII bytes for uart_tx.
// UART_REPORT_CRLF_EN appends CR LF after the 's' terminator.
module uart_report_formatter
  import uart_proto_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_report_valid,
  output logic       o_report_ready,
  input  logic [2:0] i_generator_num,
  input  logic       i_phaseupdown,
  input  logic [7:0] i_periods_done,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  input  logic       i_tx_busy,
  output logic       o_frame_done
);

  localparam int TW =
    (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST =
    TW'(ACK_TIMEOUT - 1);

  fmt_state_t state, state_n;

  logic [2:0]    gen_q;
  logic          dir_q;
  logic [2:0]    idx_q;
  logic [TW-1:0] tmr_q;
  logic [7:0]    data_q;
  logic          start_q;

  logic          accept;
  logic          fire;
  logic          bcd_done;
  logic [11:0]   bcd;
  logic [1:0]    ndig;
  logic [2:0]    stop_idx;
  logic [2:0]    last_idx;
  logic [2:0]    pos;
  logic [3:0]    digit;
  logic [7:0]    byte_n;

  bin8_to_bcd u_bcd (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (accept),
    .i_bin   (i_periods_done),
    .o_done  (bcd_done),
    .o_bcd   (bcd)
  );

  // Digit count after leading-zero suppression, and frame indices.
  always_comb begin
    ndig = 2'd1;
    if (bcd[7:4] != 4'd0) ndig = 2'd2;
    if (bcd[11:8] != 4'd0) ndig = 2'd3;
    stop_idx = {1'b0, ndig} + 3'd2;
`ifdef UART_REPORT_CRLF_EN
    last_idx = stop_idx + 3'd2;
`else
    last_idx = stop_idx;
`endif
    pos = idx_q + 3'd1 - {1'b0, ndig};
    digit = (pos == 3'd0) ? bcd[11:8] :
            (pos == 3'd1) ? bcd[7:4] :
                            bcd[3:0];
  end

  // Byte for the current index.
  always_comb begin
    byte_n = STOP_SIGNAL;
    unique case (1'b1)
      idx_q == 3'd0:
        byte_n = BASE + {5'b0, gen_q};
      idx_q == 3'd1:
        byte_n = BASE + {7'b0, dir_q};
      (idx_q >= 3'd2) && (idx_q < stop_idx):
        byte_n = ascii_digit(digit);
      idx_q == stop_idx:
        byte_n = STOP_SIGNAL;
`ifdef UART_REPORT_CRLF_EN
      idx_q == stop_idx + 3'd1:
        byte_n = CR;
      idx_q == stop_idx + 3'd2:
        byte_n = LF;
`endif
      default:
        byte_n = STOP_SIGNAL;
    endcase
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    fire    = 1'b0;
    unique case (state)
      S_IDLE, S_FINISH: begin
        state_n = S_IDLE;
        if (i_report_valid) begin
          accept  = 1'b1;
          state_n = S_CONVERT;
        end
      end
      S_CONVERT:
        if (bcd_done) state_n = S_LOAD;
      S_LOAD:
        state_n = S_START;
      S_START:
        if (!i_tx_busy) begin
          fire    = 1'b1;
          state_n = S_WAIT_ACK;
        end
      S_WAIT_ACK:
        if (i_tx_busy || tmr_q == TMR_LAST)
          state_n = S_WAIT_DONE;
      S_WAIT_DONE:
        if (!i_tx_busy)
          state_n = (idx_q == last_idx) ?
                    S_FINISH : S_LOAD;
      default:
        state_n = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Captured report fields, byte index, ack timer, tx outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gen_q   <= '0;
      dir_q   <= 1'b0;
      idx_q   <= '0;
      tmr_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= fire;
      if (accept) begin
        gen_q <= i_generator_num;
        dir_q <= i_phaseupdown;
        idx_q <= '0;
      end else if (state == S_WAIT_DONE && !i_tx_busy) begin
        idx_q <= idx_q + 3'd1;
      end
      if (state == S_LOAD) data_q <= byte_n;
      if (state == S_WAIT_ACK) tmr_q <= tmr_q + 1'b1;
      else                     tmr_q <= '0;
    end
  end

  assign o_report_ready = (state == S_IDLE) ||
                          (state == S_FINISH);
  assign o_frame_done   = (state == S_FINISH);
  assign o_tx_data      = data_q;
  assign o_tx_start     = start_q;

endmodule

// File: tb/tb_uart_report_formatter.sv
// Bench for uart_report_formatter with a uart_tx busy model.
// Expected frames come from decimal string formatting.
module tb_uart_report_formatter;

  typedef logic [7:0] bq_t[$];

  logic       i_clk;
  logic       i_rst_n;
  logic       i_report_valid;
  logic       o_report_ready;
  logic [2:0] i_generator_num;
  logic       i_phaseupdown;
  logic [7:0] i_periods_done;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       i_tx_busy;
  logic       o_frame_done;

  int   checks;
  int   errors;
  int   cyc;
  bq_t  got;
  int   st_cyc[$];
  int   viol;
  int   done_cnt;
  logic busy_m = 1'b0;
  int   bcnt;
  int   busy_len;
  logic stall;

  uart_report_formatter dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_report_valid  (i_report_valid),
    .o_report_ready  (o_report_ready),
    .i_generator_num (i_generator_num),
    .i_phaseupdown   (i_phaseupdown),
    .i_periods_done  (i_periods_done),
    .o_tx_data       (o_tx_data),
    .o_tx_start      (o_tx_start),
    .i_tx_busy       (i_tx_busy),
    .o_frame_done    (o_frame_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  assign i_tx_busy = busy_m | stall;

  // uart_tx stand-in: logs bytes, goes busy for busy_len cycles
  always @(negedge i_clk) begin
    if (o_tx_start === 1'b1) begin
      if (i_tx_busy) viol <= viol + 1;
      got.push_back(o_tx_data);
      st_cyc.push_back(cyc);
      if (busy_len > 0) begin
        busy_m <= 1'b1;
        bcnt   <= busy_len;
      end
    end else if (busy_m) begin
      if (bcnt <= 1) busy_m <= 1'b0;
      bcnt <= bcnt - 1;
    end
    if (o_frame_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic bq_t model(input logic [2:0] g,
                                input logic d,
                                input logic [7:0] p);
    bq_t   q;
    string s;
    s = $sformatf("%0d%0d%0ds", g, d, p);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
`ifdef UART_REPORT_CRLF_EN
    q.push_back(8'h0D);
    q.push_back(8'h0A);
`endif
    return q;
  endfunction

  function automatic string hexs(input bq_t q, input int from);
    string s;
    s = "";
    for (int i = from; i < q.size(); i++)
      s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic send(input logic [2:0] g, input logic d,
                      input logic [7:0] p, output int acc);
    @(negedge i_clk);
    i_generator_num = g;
    i_phaseupdown   = d;
    i_periods_done  = p;
    i_report_valid  = 1'b1;
    @(posedge i_clk);
    #1 acc = cyc;
    @(negedge i_clk);
    i_report_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge i_clk);
      #1;
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge i_clk);
      #1;
      if (got.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge i_clk);
    checks += 4;
    if (o_report_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got=%b exp=1", o_report_ready);
    end
    if (o_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_start got=%b exp=0", o_tx_start);
    end
    if (o_tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_data got=%h exp=00", o_tx_data);
    end
    if (o_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got=%b exp=0", o_frame_done);
    end
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_basic;
    int base, d0, acc;
    bit ok;
    bq_t exp;
    base = got.size();
    d0 = done_cnt;
    busy_len = 3;
    exp = model(3'd5, 1'b1, 8'd123);
    send(3'd5, 1'b1, 8'd123, acc);
    wait_done(d0 + 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout got=no_done exp=done");
    end
    checks++;
    if (hexs(got, base) != hexs(exp, 0)) begin
      errors++;
      $display("FAIL basic_bytes got=%s exp=%s",
               hexs(got, base), hexs(exp, 0));
    end
    checks++;
    if (st_cyc.size() <= base || st_cyc[base] - acc > 11) begin
      errors++;
      $display("FAIL basic_latency got=%0d exp<=11",
               (st_cyc.size() > base) ? st_cyc[base] - acc : -1);
    end
    repeat (20) @(negedge i_clk);
    checks += 2;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL basic_done_cnt got=%0d exp=%0d",
               done_cnt - d0, 1);
    end
    if (o_report_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready got=%b exp=1", o_report_ready);
    end
  endtask

  task automatic test_small;
    logic [2:0] gs[2] = '{3'd0, 3'd2};
    logic [7:0] ps[2] = '{8'd0, 8'd7};
    int base, d0, acc;
    bit ok;
    bq_t exp;
    busy_len = 2;
    for (int i = 0; i < 2; i++) begin
      base = got.size();
      d0 = done_cnt;
      exp = model(gs[i], 1'b0, ps[i]);
      send(gs[i], 1'b0, ps[i], acc);
      wait_done(d0 + 1, ok);
      checks++;
      if (!ok || hexs(got, base) != hexs(exp, 0)) begin
        errors++;
        $display("FAIL small_%0d got=%s exp=%s", i,
                 hexs(got, base), hexs(exp, 0));
      end
    end
  endtask

  task automatic test_max_stall;
    int base, d0, v0, acc;
    bit ok;
    bq_t exp;
    base = got.size();
    d0 = done_cnt;
    v0 = viol;
    busy_len = 4;
    stall = 1'b1;
    exp = model(3'd7, 1'b0, 8'd255);
    send(3'd7, 1'b0, 8'd255, acc);
    repeat (40) @(negedge i_clk);
    checks++;
    if (got.size() != base) begin
      errors++;
      $display("FAIL stall_hold got=%0d exp=0 bytes",
               got.size() - base);
    end
    stall = 1'b0;
    wait_done(d0 + 1, ok);
    checks += 2;
    if (!ok || hexs(got, base) != hexs(exp, 0)) begin
      errors++;
      $display("FAIL stall_bytes got=%s exp=%s",
               hexs(got, base), hexs(exp, 0));
    end
    if (viol != v0) begin
      errors++;
      $display("FAIL stall_viol got=%0d exp=0", viol - v0);
    end
  endtask

  task automatic test_no_busy;
    int base, d0, acc, bad;
    bit ok;
    bq_t exp;
    logic [2:0] g;
    logic d;
    logic [7:0] p;
    g = 3'($urandom_range(0, 7));
    d = 1'($urandom_range(0, 1));
    p = 8'($urandom_range(100, 255));
    base = got.size();
    d0 = done_cnt;
    busy_len = 0;
    exp = model(g, d, p);
    send(g, d, p, acc);
    wait_done(d0 + 1, ok);
    checks++;
    if (!ok || hexs(got, base) != hexs(exp, 0)) begin
      errors++;
      $display("FAIL nobusy_bytes got=%s exp=%s",
               hexs(got, base), hexs(exp, 0));
    end
    bad = 0;
    for (int i = base + 1; i < st_cyc.size(); i++)
      if (st_cyc[i] - st_cyc[i-1] < 16) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nobusy_gap got=%0d short exp=0", bad);
    end
  endtask

  task automatic test_mid_valid;
    int base, d0, acc;
    bit ok;
    bq_t exp;
    base = got.size();
    d0 = done_cnt;
    busy_len = 4;
    exp = model(3'd3, 1'b1, 8'd45);
    send(3'd3, 1'b1, 8'd45, acc);
    wait_bytes(base + 2, ok);
    @(negedge i_clk);
    i_generator_num = 3'd6;
    i_phaseupdown   = 1'b0;
    i_periods_done  = 8'd200;
    i_report_valid  = 1'b1;
    @(negedge i_clk);
    i_report_valid  = 1'b0;
    wait_done(d0 + 1, ok);
    checks++;
    if (!ok || hexs(got, base) != hexs(exp, 0)) begin
      errors++;
      $display("FAIL midvalid_bytes got=%s exp=%s",
               hexs(got, base), hexs(exp, 0));
    end
    repeat (80) @(negedge i_clk);
    checks++;
    if (done_cnt != d0 + 1 || got.size() != base + exp.size()) begin
      errors++;
      $display("FAIL midvalid_extra got=%0d frames exp=1",
               done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int base, d0, acc;
    bit ok;
    base = got.size();
    d0 = done_cnt;
    busy_len = 3;
    send(3'd4, 1'b1, 8'd188, acc);
    wait_bytes(base + 2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rstmid_wait got=%0d exp=2 bytes",
               got.size() - base);
    end
    i_rst_n = 1'b0;
    #1;
    checks += 2;
    if (o_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_start got=%b exp=0", o_tx_start);
    end
    if (o_report_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready got=%b exp=1", o_report_ready);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (60) @(negedge i_clk);
    checks++;
    if (got.size() != base + 2 || done_cnt != d0) begin
      errors++;
      $display("FAIL rstmid_more got=%0d bytes exp=2",
               got.size() - base);
    end
  endtask

  task automatic test_random;
    int base, d0, acc, v0;
    bit ok;
    bq_t exp;
    logic [2:0] g;
    logic d;
    logic [7:0] p;
    v0 = viol;
    for (int n = 0; n < 8; n++) begin
      g = 3'($urandom_range(0, 7));
      d = 1'($urandom_range(0, 1));
      p = 8'($urandom_range(0, 255));
      busy_len = $urandom_range(0, 5);
      base = got.size();
      d0 = done_cnt;
      exp = model(g, d, p);
      send(g, d, p, acc);
      wait_done(d0 + 1, ok);
      checks++;
      if (!ok || hexs(got, base) != hexs(exp, 0)) begin
        errors++;
        $display("FAIL random_%0d got=%s exp=%s", n,
                 hexs(got, base), hexs(exp, 0));
      end
    end
    checks++;
    if (viol != v0) begin
      errors++;
      $display("FAIL random_viol got=%0d exp=0", viol - v0);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    i_rst_n         = 1'b0;
    i_report_valid  = 1'b0;
    i_generator_num = 3'd0;
    i_phaseupdown   = 1'b0;
    i_periods_done  = 8'd0;
    stall           = 1'b0;
    busy_len        = 2;
    test_reset;
    test_basic;
    test_small;
    test_max_stall;
    test_no_busy;
    test_mid_valid;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
